// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the
// valid/ready instruction handshake toward the control unit.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic [15:0]       command;
    logic [15:0]       number;
    logic [15:0]       address;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output imem_rd, imem_addr, command, number, address, instr_valid,
        input  imem_data, instr_ready
    );

    modport slave (
        input  imem_rd, imem_addr, command, number, address, instr_valid,
        output imem_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: reads three-word instructions from a synchronous-read memory and
// issues them under valid/ready. Optional local jumps via INSTR_FETCH_JUMP_EN.
module instr_fetch #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     bus,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o
);
    typedef enum logic [2:0] {BOOT, F0, F1, F2, F3, ISSUE, HALT} state_t;

    localparam logic [3:0] OP_HALT = 4'b1111;
`ifdef INSTR_FETCH_JUMP_EN
    localparam logic [3:0] OP_JUMP = 4'b0101;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       adr_q, adr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cmd_q   <= '0;
            num_q   <= '0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            num_q   <= num_d;
            adr_q   <= adr_d;
        end
    end

    // Memory data always belongs to the read issued in the previous state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cmd_d         = cmd_q;
        num_d         = num_q;
        adr_d         = adr_q;
        bus.imem_rd   = 1'b0;
        bus.imem_addr = pc_q;
        case (state_q)
            BOOT: state_d = F0;
            F0: begin
                bus.imem_rd = 1'b1;
                state_d     = F1;
            end
            F1: begin
                cmd_d = bus.imem_data;
                if (bus.imem_data[15:12] == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    bus.imem_rd   = 1'b1;
                    bus.imem_addr = pc_q + ADDR_W'(1);
                    state_d       = F2;
                end
            end
            F2: begin
                num_d         = bus.imem_data;
                bus.imem_rd   = 1'b1;
                bus.imem_addr = pc_q + ADDR_W'(2);
                state_d       = F3;
            end
            F3: begin
                adr_d   = bus.imem_data;
                pc_d    = pc_q + ADDR_W'(3);
                state_d = ISSUE;
`ifdef INSTR_FETCH_JUMP_EN
                if (cmd_q[15:12] == OP_JUMP) begin
                    pc_d    = bus.imem_data[ADDR_W-1:0];
                    state_d = F0;
                end
`endif
            end
            ISSUE: begin
                if (bus.instr_ready) state_d = F0;
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.command     = cmd_q;
    assign bus.number      = num_q;
    assign bus.address     = adr_q;
    assign pc_o            = pc_q;
    assign halted_o        = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table for fetch/backpressure/HALT
// (with a 4-bit wrap instance alongside), plus hand sequences for reset and jump.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(8)) bus_a ();
    instr_fetch_if #(.ADDR_W(4)) bus_b ();
    logic [7:0] pc_a;
    logic       halted_a;
    logic [3:0] pc_b;
    logic       halted_b;

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'd0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .pc_o(pc_a), .halted_o(halted_a));
    instr_fetch #(.ADDR_W(4), .RESET_PC(4'd14)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .pc_o(pc_b), .halted_o(halted_b));

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [16];
    always @(posedge clk) if (bus_a.imem_rd) bus_a.imem_data <= mem_a[bus_a.imem_addr];
    always @(posedge clk) if (bus_b.imem_rd) bus_b.imem_data <= mem_b[bus_b.imem_addr];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit          ready;
        bit          rd;
        logic [7:0]  addr;
        bit          valid;
        logic [7:0]  pc;
        bit          halted;
        logic [15:0] cmd, num, adr;
        bit          b_rd;
        logic [3:0]  b_addr, b_pc;
    } vec_t;

    function automatic vec_t mk(bit r, bit rd, logic [7:0] a, bit v, logic [7:0] p, bit h,
                                logic [15:0] c, logic [15:0] n, logic [15:0] d,
                                bit brd, logic [3:0] ba, logic [3:0] bp);
        vec_t t;
        t.ready = r; t.rd = rd; t.addr = a; t.valid = v; t.pc = p; t.halted = h;
        t.cmd = c; t.num = n; t.adr = d; t.b_rd = brd; t.b_addr = ba; t.b_pc = bp;
        return t;
    endfunction

    vec_t vecs [19];

    task automatic reset_release();
        rst_n = 1'b0;
        bus_a.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd"},    bus_a.imem_rd, 1'b0);
        chk({tag, "_addr"},  bus_a.imem_addr, 8'd0);
        chk({tag, "_valid"}, bus_a.instr_valid, 1'b0);
        chk({tag, "_pc"},    pc_a, 8'd0);
        chk({tag, "_halt"},  halted_a, 1'b0);
        chk({tag, "_cmd"},   bus_a.command, 16'h0);
        chk({tag, "_num"},   bus_a.number, 16'h0);
        chk({tag, "_adr"},   bus_a.address, 16'h0);
        chk({tag, "_b_addr"}, bus_b.imem_addr, 4'd14);
        chk({tag, "_b_pc"},  pc_b, 4'd14);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem_a[i]) mem_a[i] = 16'h0;
        foreach (mem_b[i]) mem_b[i] = 16'h0;
        mem_a[0] = 16'h4001; mem_a[1] = 16'h0007; mem_a[2] = 16'h0010; mem_a[3] = 16'hF000;
        mem_b[14] = 16'h2001; mem_b[15] = 16'h0002; mem_b[0] = 16'h0003;
        bus_a.instr_ready = 1'b0;
        bus_b.instr_ready = 1'b0;

        //     ready rd addr valid pc halt  cmd      num      adr       b_rd b_addr b_pc
        vecs[0]  = mk(0, 0, 8'd0, 0, 8'd0, 0, 16'h0,    16'h0,    16'h0,    0, 4'd14, 4'd14);
        vecs[1]  = mk(0, 1, 8'd0, 0, 8'd0, 0, 16'h0,    16'h0,    16'h0,    1, 4'd14, 4'd14);
        vecs[2]  = mk(0, 1, 8'd1, 0, 8'd0, 0, 16'h0,    16'h0,    16'h0,    1, 4'd15, 4'd14);
        vecs[3]  = mk(0, 1, 8'd2, 0, 8'd0, 0, 16'h4001, 16'h0,    16'h0,    1, 4'd0,  4'd14);
        vecs[4]  = mk(0, 0, 8'd0, 0, 8'd0, 0, 16'h4001, 16'h0007, 16'h0,    0, 4'd14, 4'd14);
        for (int i = 5; i < 15; i++)
            vecs[i] = mk(0, 0, 8'd3, 1, 8'd3, 0, 16'h4001, 16'h0007, 16'h0010, 0, 4'd1, 4'd1);
        vecs[15] = mk(1, 0, 8'd3, 1, 8'd3, 0, 16'h4001, 16'h0007, 16'h0010, 0, 4'd1, 4'd1);
        vecs[16] = mk(1, 1, 8'd3, 0, 8'd3, 0, 16'h4001, 16'h0007, 16'h0010, 0, 4'd1, 4'd1);
        vecs[17] = mk(1, 0, 8'd3, 0, 8'd3, 0, 16'h4001, 16'h0007, 16'h0010, 0, 4'd1, 4'd1);
        vecs[18] = mk(0, 0, 8'd3, 0, 8'd3, 1, 16'hF000, 16'h0007, 16'h0010, 0, 4'd1, 4'd1);

        // Reset values while reset is held
        #12;
        chk_reset_vals("in_reset");
        $display("reset held: rd=%0b pc=%0h valid=%0b", bus_a.imem_rd, pc_a, bus_a.instr_valid);

        // Vector table: fetch, backpressure, ready pulse, HALT fetch
        reset_release();
        for (int i = 0; i < 19; i++) begin
            bus_a.instr_ready = vecs[i].ready;
            #1;
            $display("cycle %0d: ready=%0b rd=%0b addr=%0h valid=%0b pc=%0h halted=%0b cmd=%h",
                     i, vecs[i].ready, bus_a.imem_rd, bus_a.imem_addr, bus_a.instr_valid,
                     pc_a, halted_a, bus_a.command);
            chk($sformatf("v%0d_rd", i),     bus_a.imem_rd, vecs[i].rd);
            chk($sformatf("v%0d_addr", i),   bus_a.imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i),  bus_a.instr_valid, vecs[i].valid);
            chk($sformatf("v%0d_pc", i),     pc_a, vecs[i].pc);
            chk($sformatf("v%0d_halted", i), halted_a, vecs[i].halted);
            chk($sformatf("v%0d_cmd", i),    bus_a.command, vecs[i].cmd);
            chk($sformatf("v%0d_num", i),    bus_a.number, vecs[i].num);
            chk($sformatf("v%0d_adr", i),    bus_a.address, vecs[i].adr);
            chk($sformatf("v%0d_b_rd", i),   bus_b.imem_rd, vecs[i].b_rd);
            chk($sformatf("v%0d_b_addr", i), bus_b.imem_addr, vecs[i].b_addr);
            chk($sformatf("v%0d_b_pc", i),   pc_b, vecs[i].b_pc);
            @(negedge clk);
        end

        // HALT persists with no reads, even with ready high
        bus_a.instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("halt%0d", i),
                {bus_a.imem_rd, bus_a.instr_valid, halted_a, pc_a}, {1'b0, 1'b0, 1'b1, 8'd3});
            @(negedge clk);
        end
        $display("halt hold: halted=%0b pc=%0h", halted_a, pc_a);

        // Wrap instance issued the straddling instruction and is still holding it
        chk("wrap_valid", bus_b.instr_valid, 1'b1);
        chk("wrap_cmd",   bus_b.command, 16'h2001);
        chk("wrap_num",   bus_b.number, 16'h0002);
        chk("wrap_adr",   bus_b.address, 16'h0003);
        $display("wrap: cmd=%h num=%h adr=%h pc=%0h", bus_b.command, bus_b.number, bus_b.address, pc_b);

        // Asynchronous reset in the middle of F2, then clean restart
        reset_release();
        repeat (3) @(negedge clk);
        #1;
        chk("midf2_rd",   bus_a.imem_rd, 1'b1);
        chk("midf2_addr", bus_a.imem_addr, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        $display("mid-F2 reset: cmd=%h pc=%0h rd=%0b", bus_a.command, pc_a, bus_a.imem_rd);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.instr_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("restart_c%0d_valid", c), bus_a.instr_valid, (c == 5));
        end
        chk("restart_cmd", bus_a.command, 16'h4001);
        chk("restart_pc",  pc_a, 8'd3);
        $display("restart: valid=%0b cmd=%h pc=%0h", bus_a.instr_valid, bus_a.command, pc_a);

        // Opcode 0101: local jump when enabled, otherwise issued like any opcode
        mem_a[0] = 16'h5000; mem_a[1] = 16'h0000; mem_a[2] = 16'h0020;
        mem_a[8'h20] = 16'h1234; mem_a[8'h21] = 16'h5678; mem_a[8'h22] = 16'h9ABC;
        reset_release();
`ifdef INSTR_FETCH_JUMP_EN
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); #1;
            chk($sformatf("jump_c%0d_valid", c), bus_a.instr_valid, (c == 9));
            if (c == 5) begin
                chk("jump_rd",   bus_a.imem_rd, 1'b1);
                chk("jump_addr", bus_a.imem_addr, 8'h20);
            end
        end
        chk("jump_cmd", bus_a.command, 16'h1234);
        chk("jump_pc",  pc_a, 8'h23);
`else
        repeat (5) @(negedge clk);
        #1;
        chk("nojump_valid", bus_a.instr_valid, 1'b1);
        chk("nojump_cmd",   bus_a.command, 16'h5000);
        chk("nojump_adr",   bus_a.address, 16'h0020);
        chk("nojump_pc",    pc_a, 8'd3);
`endif
        $display("opcode 5: valid=%0b cmd=%h pc=%0h", bus_a.instr_valid, bus_a.command, pc_a);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Front-end fetch stage that sits directly upstream of the control unit. Walks a program counter through a word-addressed, synchronous-read instruction memory, assembles each three-word instruction (command, number, address), and presents it to the control unit under a valid/ready handshake. Detects HALT and, optionally, executes unconditional jumps locally without involving the control unit.

## Interface
- ADDR_W, 8, instruction memory address width; PC width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_rd  out  1  instruction memory read strobe
- imem_addr  out  ADDR_W  instruction memory read address
- imem_data  in  16  read data, valid exactly one cycle after imem_rd
- command  out  16  instruction word 0: opcode in [15:12], sub in [3], op_select in [2:0]
- number  out  16  instruction word 1, immediate operand
- address  out  16  instruction word 2, data-memory address or jump target
- instr_valid  out  1  command/number/address hold a complete instruction
- instr_ready  in  1  control unit accepts the instruction this cycle
- pc  out  ADDR_W  address of the next instruction to fetch
- halted  out  1  HALT fetched; fetch stopped

## Operation
- States: BOOT, F0, F1, F2, F3, ISSUE, HALT.
- BOOT: imem_rd=0; goes to F0 next cycle.
- F0: imem_rd=1, imem_addr=pc; goes to F1.
- F1: command<=imem_data; imem_rd=1, imem_addr=pc+1; if imem_data[15:12]==4'b1111 go to HALT (no further read: imem_rd=0 in this case), else F2.
- F2: number<=imem_data; imem_rd=1, imem_addr=pc+2; goes to F3.
- F3: address<=imem_data; pc<=pc+3; imem_rd=0; goes to ISSUE.
- ISSUE: instr_valid=1; command/number/address stable; on instr_ready go to F0, else hold.
- HALT: halted=1, imem_rd=0; pc unchanged (still points at the HALT word); exits only on reset.
- instr_ready outside ISSUE is ignored.
- All other opcodes, including 0000 and unrecognised values, are issued unchanged; decode belongs to the control unit.
- Arithmetic: pc, pc+1, pc+2, pc+3 are modulo 2^ADDR_W; an instruction straddling the top of memory wraps to address 0.
- imem_rd/imem_addr are combinational from state and pc; imem_addr=pc in every state where imem_rd=0.

## Timing
- Reset values: imem_rd=0, imem_addr=RESET_PC, command=0, number=0, address=0, instr_valid=0, pc=RESET_PC, halted=0; state=BOOT.
- Reset asserted mid-fetch or mid-ISSUE: all outputs take reset values immediately; in-flight memory data is discarded; the fetch restarts from RESET_PC.
- First instr_valid: 5 cycles after rst deasserts (BOOT, F0, F1, F2, F3, then valid in ISSUE).
- Back-to-back throughput: one instruction per 5 cycles when instr_ready is held high (ISSUE to F0 to F1 to F2 to F3 to ISSUE).
- instr_valid drops the cycle after the handshake completes; it never drops without instr_ready.
- HALT: halted rises the cycle after F1; instr_valid stays 0.

## Configuration
- INSTR_FETCH_JUMP_EN defined: opcode 4'b0101 is a jump. In F3, pc<=address[ADDR_W-1:0] instead of pc+3, and the state goes to F0; instr_valid is never raised for the jump. Jump cost is 4 cycles (F0 to F3).
- Undefined: opcode 0101 is issued to the control unit like any other opcode.

## Test plan
- Reset then fetch: mem[0..2]=4001,0007,0010, instr_ready=1 -> instr_valid high on cycle 5 with command=4001, number=0007, address=0010; pc=3.
- Backpressure: instr_ready=0 for 10 cycles -> instr_valid stays high, fields stable, no imem_rd; ready pulse -> valid drops next cycle, next fetch at pc=3.
- HALT: mem[3]=F000 -> halted=1, instr_valid stays 0, pc=3, imem_rd stays 0 for 20 cycles.
- Wrap: ADDR_W=4, RESET_PC=14 -> reads at 14, 15, 0; pc becomes 1.
- Jump (INSTR_FETCH_JUMP_EN): mem[0..2]=5000,0000,0020 -> no instr_valid; next imem_addr=0x20. Without the macro -> issued with command=5000.
- Reset mid-F2 -> outputs return to reset values; the fetch restarts at RESET_PC with a clean 5-cycle latency.
